// File: rtl/mul_sequencer.sv
// Iterative shift-add multiplier that stalls the pipeline for WIDTH+1 cycles
// and returns the low WIDTH bits of A*B with a one-cycle Done pulse.
module mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Stall,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] acc_next;

  // Modular add: the carry out of the top bit is deliberately dropped.
  function automatic logic [WIDTH-1:0] add_wrap(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    return x + y;
  endfunction

  assign acc_next = mplier[0] ? add_wrap(acc, mcand) : acc;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      Result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            mcand  <= A;
            mplier <= B;
            acc    <= '0;
            count  <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CNT_W'(1);
          // Final step folds into Result directly so DONE sees the full product.
          if (count == LAST) begin
            Result <= acc_next;
            state  <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stall must drop while reset is held even if the state register is still stale.
  assign Stall = Rst_n & (((state == IDLE) & Start) | (state == RUN));
  assign Busy  = (state == RUN);
  assign Done  = (state == DONE);

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer: reset, latency, wraparound, operand
// isolation, back-to-back issue and reset abort.
module tb_mul_sequencer;

  localparam int W = 32;

  logic         Clk;
  logic         Rst_n;
  logic         Start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Stall;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Result;

  int total = 0;
  int bad   = 0;

  mul_sequencer #(.WIDTH(W)) dut (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .Start  (Start),
    .A      (A),
    .B      (B),
    .Stall  (Stall),
    .Busy   (Busy),
    .Done   (Done),
    .Result (Result)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0; Start = 1'b1; A = 32'd7; B = 32'd6;
    tick(); tick();
    total++; if (Stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", Stall); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", Busy); end
    total++; if (Done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", Done); end
    total++; if (Result !== 32'd0) begin bad++; $display("FAIL reset_result got=%h want=0", Result); end
    Rst_n = 1'b1; Start = 1'b0;
    tick();
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b want=0", Busy); end
  endtask

  // Issues one MUL from IDLE and returns in its DONE cycle with Start still held.
  task automatic mul_core(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] expv, input bit perturb, input string nm);
    int cyc, stall_n, busy_n;
    bit seen;
    A = a; B = b; Start = 1'b1;
    #1;
    total++; if (Stall !== 1'b1) begin bad++; $display("FAIL %s stall_c0 got=%b want=1", nm, Stall); end
    stall_n = (Stall === 1'b1) ? 1 : 0;
    busy_n = 0; cyc = 0; seen = 0;
    while (!seen && cyc < 40) begin
      tick();
      cyc++;
      if (perturb && cyc == 5) begin A = 32'd100; B = 32'd100; end
      if (Done === 1'b1) seen = 1;
      else begin
        if (Stall === 1'b1) stall_n++;
        if (Busy === 1'b1) busy_n++;
      end
    end
    total++; if (!seen) begin bad++; $display("FAIL %s timeout got=no_done want=done", nm); end
    total++; if (cyc != W + 1) begin bad++; $display("FAIL %s done_cycle got=%0d want=%0d", nm, cyc, W + 1); end
    total++; if (stall_n != W + 1) begin bad++; $display("FAIL %s stall_cycles got=%0d want=%0d", nm, stall_n, W + 1); end
    total++; if (busy_n != W) begin bad++; $display("FAIL %s busy_cycles got=%0d want=%0d", nm, busy_n, W); end
    total++; if (Stall !== 1'b0) begin bad++; $display("FAIL %s stall_at_done got=%b want=0", nm, Stall); end
    total++; if (Result !== expv) begin bad++; $display("FAIL %s result got=%h want=%h", nm, Result, expv); end
  endtask

  // Leaves DONE with Start still high (must be ignored), then drops Start.
  task automatic retire(input logic [W-1:0] expv, input string nm);
    tick();
    total++; if (Done !== 1'b0) begin bad++; $display("FAIL %s done_width got=%b want=0", nm, Done); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL %s start_in_done got=%b want=0", nm, Busy); end
    Start = 1'b0;
    #1;
    total++; if (Stall !== 1'b0) begin bad++; $display("FAIL %s idle_stall got=%b want=0", nm, Stall); end
    tick(); tick(); tick();
    total++; if (Result !== expv) begin bad++; $display("FAIL %s result_hold got=%h want=%h", nm, Result, expv); end
    total++; if (Done !== 1'b0 || Busy !== 1'b0) begin bad++; $display("FAIL %s idle_quiet got=%b%b want=00", nm, Done, Busy); end
  endtask

  task automatic test_basic();
    mul_core(32'd7, 32'd6, 32'd42, 1'b0, "basic");
    retire(32'd42, "basic");
  endtask

  task automatic test_signed_overflow();
    mul_core(32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 1'b0, "signed");
    retire(32'hFFFF_FFF1, "signed");
    mul_core(32'h8000_0000, 32'd2, 32'd0, 1'b0, "overflow");
    retire(32'd0, "overflow");
  endtask

  task automatic test_isolation();
    mul_core(32'd3, 32'd4, 32'd12, 1'b1, "isolation");
    retire(32'd12, "isolation");
  endtask

  task automatic test_back_to_back();
    mul_core(32'd9, 32'd9, 32'd81, 1'b0, "b2b_first");
    A = 32'd2; B = 32'h4000_0000;
    tick();
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL b2b_gap_busy got=%b want=0", Busy); end
    total++; if (Stall !== 1'b1) begin bad++; $display("FAIL b2b_gap_stall got=%b want=1", Stall); end
    total++; if (Result !== 32'd81) begin bad++; $display("FAIL b2b_gap_result got=%h want=%h", Result, 32'd81); end
    mul_core(32'd2, 32'h4000_0000, 32'h8000_0000, 1'b0, "b2b_second");
    retire(32'h8000_0000, "b2b_second");
  endtask

  task automatic test_abort();
    int dones;
    A = 32'd5; B = 32'd5; Start = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    total++; if (Busy !== 1'b1) begin bad++; $display("FAIL abort_running got=%b want=1", Busy); end
    Rst_n = 1'b0; Start = 1'b0;
    #1;
    total++; if (Stall !== 1'b0) begin bad++; $display("FAIL abort_stall got=%b want=0", Stall); end
    tick();
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", Busy); end
    total++; if (Result !== 32'd0) begin bad++; $display("FAIL abort_result got=%h want=0", Result); end
    Rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 35; i++) begin
      tick();
      if (Done === 1'b1) dones++;
    end
    total++; if (dones != 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", dones); end
    mul_core(32'd5, 32'd5, 32'd25, 1'b0, "after_abort");
    retire(32'd25, "after_abort");
  endtask

  initial begin
    Rst_n = 1'b0; Start = 1'b0; A = '0; B = '0;
    test_reset();
    test_basic();
    test_signed_overflow();
    test_isolation();
    test_back_to_back();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
